proc_cfg_sequencer: RTL
=======================

Name: proc_cfg_sequencer

Overview:
Configuration controller for data_proc. It accepts one mode/kernel command at a time and holds it until the current frame ends. At the frame boundary it issues the required register writes on data_proc's config port (addr_in/wr_data_in/write_en). This keeps mode and kernel changes frame-aligned, so no frame is processed with a mixed mode or a partially loaded kernel. It sits in the clk domain beside data_proc and is driven by system control logic.

Parameters:
FRAME_PIXELS, 1024, output beats per frame; pixel counter wraps at FRAME_PIXELS-1
GAP_CYCLES, 1, idle cycles with write_en low after each write pulse (min 1)

Ports:
clk  in  1  system clock (data_proc clk domain)
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_mode  in  2  0 bypass, 1 invert, 2 convolution, 3 illegal
cmd_kern_bot  in  32  kernel word written to addr 0x04 (mode 2 only)
cmd_kern_mid  in  32  kernel word written to addr 0x08
cmd_kern_top  in  32  kernel word written to addr 0x0C
pix_beat  in  1  one output pixel transferred (data_proc valid_out)
addr_out  out  5  to data_proc addr_in
wr_data_out  out  32  to data_proc wr_data_in
write_en_out  out  1  to data_proc write_en, one-cycle pulses
rd_data_in  in  32  from data_proc rd_data_out (used only with CFG_READBACK_EN)
busy  out  1  high outside IDLE
cur_mode  out  2  last mode fully written
cfg_done  out  1  one-cycle pulse when a command's write sequence completes
err_mode  out  1  one-cycle pulse on acceptance of cmd_mode==3
err_rb  out  1  sticky readback mismatch; cleared only by reset

Behaviour:
- Reset (async, rstn low): all state is cleared and any pending command is dropped. Outputs reset to: cmd_ready=0, addr_out=0, wr_data_out=0, write_en_out=0, busy=0, cur_mode=0, cfg_done=0, err_mode=0, err_rb=0, pix_cnt=0. cmd_ready goes to 1 on the first clk after reset release.
- pix_cnt increments on every pix_beat in all states and wraps from FRAME_PIXELS-1 to 0. Frame boundary = pix_beat && pix_cnt==FRAME_PIXELS-1.
- States: IDLE, ARMED, WRITE, GAP (VERIFY with the macro).
- IDLE: cmd_ready=1. On accept, the command is registered.
  - mode 3: pulse err_mode next cycle, no writes, remain in IDLE.
  - otherwise: go to ARMED. cmd_ready is 0 in every state except IDLE.
- ARMED: wait for a frame boundary. The boundary cycle itself transitions to WRITE, and the first write_en_out is asserted the following cycle.
- Write list:
  - modes 0/1: (0x00, mode).
  - mode 2: (0x04, bot), (0x08, mid), (0x0C, top), (0x00, 2). Mode is written last so convolution never runs on a stale kernel.
- WRITE: drive addr_out/wr_data_out with the list entry and set write_en_out=1 for exactly one cycle, then go to GAP.
- GAP: write_en_out=0 with addr/data held for GAP_CYCLES cycles. Then either advance to the next entry (WRITE), or, after the last entry, update cur_mode, pulse cfg_done, and return to IDLE.
- Latency: a mode 0/1 command completes 1+1+GAP_CYCLES cycles after the boundary cycle; mode 2 completes 4*(1+GAP_CYCLES)+1.
- pix_beats that arrive during WRITE/GAP still count; no handshake with data_proc is back-pressured.
- A boundary that occurs while in WRITE/GAP is ignored, since no command is pending.
- cmd_valid with unstable payload before acceptance is not supported; the payload is sampled only on accept.

Optional Feature:
CFG_READBACK_EN
- Defined: after each GAP a VERIFY state lasts one cycle. addr_out is held, and rd_data_in is compared with the written word. On mismatch err_rb is set (sticky) and the sequence continues. Latency per entry increases by 1.
- Undefined: there is no VERIFY state, rd_data_in is ignored, and err_rb is tied to 0.

Test Plan:
- Reset → all outputs 0. Release rstn → cmd_ready=1 after one clk. Assert rstn mid-WRITE → write_en_out drops to 0 immediately (async) and the pending command is not reissued.
- FRAME_PIXELS=16, cmd_mode=1 accepted at pix_cnt=5 → no write until the 16th beat. Next cycle: exactly one pulse addr 0x00 data 0x1, then cfg_done=1 and cur_mode=1.
- cmd_mode=2, bot=0x0, mid=0x01000000, top=0x0 → writes 0x04/0x0, 0x08/0x01000000, 0x0C/0x0, 0x00/0x2 in that order, each write_en pulse separated by GAP_CYCLES=1 low cycle; cfg_done 9 cycles after the boundary.
- cmd_mode=3 → cmd_ready stays 1, err_mode pulses once, no write_en_out, cur_mode unchanged.
- Back-to-back commands: cmd_valid held with a 2nd command → cmd_ready=0 through ARMED/WRITE/GAP. The 2nd command is accepted the cycle after cfg_done and waits for the following frame boundary.
- CFG_READBACK_EN with a rd_data_in model returning 0xFFFFFFFF on addr 0x08 → err_rb=1 after the mid write and stays 1; all 4 writes still complete; cfg_done pulses.

Source files
------------

// File: rtl/proc_cfg_sequencer.sv
// proc_cfg_sequencer
//   Frame-aligned configuration controller for data_proc. Takes one
//   mode/kernel command at a time and holds it until the end of the
//   current frame. At the frame boundary it issues the register writes
//   on data_proc's config port, so no frame ever runs with a mixed mode
//   or a partially loaded kernel.
//
//   Build option: CFG_READBACK_EN adds a one-cycle VERIFY step after each
//   write gap. In that step rd_data_in is compared with the word just
//   written, and err_rb latches any mismatch.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (accepted only in IDLE)
//   cmd_mode                       0 bypass, 1 invert, 2 convolution, 3 illegal
//   cmd_kern_bot/mid/top           kernel words for 0x04/0x08/0x0C
//   pix_beat                       one output pixel of data_proc
//   addr_out/wr_data_out           config address/data to data_proc
//   write_en_out                   one-cycle write strobe
//   rd_data_in                     data_proc readback (CFG_READBACK_EN only)
//   busy                           high outside IDLE
//   cur_mode                       last mode fully written
//   cfg_done                       pulse when a write sequence completes
//   err_mode                       pulse when a mode-3 command is accepted
//   err_rb                         sticky readback mismatch
//
// state  | meaning
// IDLE   | ready for a command
// ARMED  | command held, waiting for the frame boundary
// WRITE  | write_en_out high for the current entry
// GAP    | write_en_out low, addr/data held for GAP_CYCLES cycles
// VERIFY | (CFG_READBACK_EN) compare readback with the written word
module proc_cfg_sequencer #(
   parameter int FRAME_PIXELS = 1024,
   parameter int GAP_CYCLES   = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_mode,
   input  logic [31:0] cmd_kern_bot,
   input  logic [31:0] cmd_kern_mid,
   input  logic [31:0] cmd_kern_top,
   input  logic        pix_beat,
   output logic [4:0]  addr_out,
   output logic [31:0] wr_data_out,
   output logic        write_en_out,
   input  logic [31:0] rd_data_in,
   output logic        busy,
   output logic [1:0]  cur_mode,
   output logic        cfg_done,
   output logic        err_mode,
   output logic        err_rb
);

   localparam int PW = (FRAME_PIXELS > 2) ? $clog2(FRAME_PIXELS) : 1;
   localparam logic [PW-1:0] PIX_LAST = PW'(FRAME_PIXELS - 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WRITE, S_GAP, S_VERIFY} state_t;

   state_t        state;
   logic [PW-1:0] pix_cnt;
   logic [GW-1:0] gap_cnt;
   logic [1:0]    idx;
   logic [1:0]    mode_q;
   logic [31:0]   bot_q, mid_q, top_q;

   logic          boundary;
   logic          last_entry;
   logic          entry_end;
   logic [1:0]    nxt_idx;
   logic [4:0]    nxt_addr;
   logic [31:0]   nxt_data;

   // Convolution writes the kernel first and the mode word last, so the
   // new mode never becomes active on a stale kernel.
   function automatic logic [4:0] entry_addr(input logic [1:0] mode, input logic [1:0] i);
      if (mode != 2'd2) return 5'h00;
      case (i)
         2'd0:    return 5'h04;
         2'd1:    return 5'h08;
         2'd2:    return 5'h0C;
         default: return 5'h00;
      endcase
   endfunction

   function automatic logic [31:0] entry_data(input logic [1:0] mode, input logic [1:0] i,
                                              input logic [31:0] bot, input logic [31:0] mid,
                                              input logic [31:0] top);
      if (mode != 2'd2) return {30'd0, mode};
      case (i)
         2'd0:    return bot;
         2'd1:    return mid;
         2'd2:    return top;
         default: return 32'd2;
      endcase
   endfunction

   assign boundary   = pix_beat && (pix_cnt == PIX_LAST);
   assign last_entry = (mode_q != 2'd2) || (idx == 2'd3);

   always_comb begin
      nxt_idx  = idx + 2'd1;
      nxt_addr = entry_addr(mode_q, nxt_idx);
      nxt_data = entry_data(mode_q, nxt_idx, bot_q, mid_q, top_q);
   end

`ifdef CFG_READBACK_EN
   assign entry_end = (state == S_VERIFY);
`else
   assign entry_end = (state == S_GAP) && (gap_cnt == '0);
   assign err_rb    = 1'b0;
   logic unused_rd;
   assign unused_rd = ^rd_data_in;
`endif

   // The pixel counter runs in every state so frame position is never lost.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pix_cnt <= '0;
      end else if (pix_beat) begin
         pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         cmd_ready    <= 1'b0;
         addr_out     <= '0;
         wr_data_out  <= '0;
         write_en_out <= 1'b0;
         busy         <= 1'b0;
         cur_mode     <= '0;
         cfg_done     <= 1'b0;
         err_mode     <= 1'b0;
         gap_cnt      <= '0;
         idx          <= '0;
         mode_q       <= '0;
         bot_q        <= '0;
         mid_q        <= '0;
         top_q        <= '0;
`ifdef CFG_READBACK_EN
         err_rb       <= 1'b0;
`endif
      end else begin
         cfg_done     <= 1'b0;
         err_mode     <= 1'b0;
         write_en_out <= 1'b0;
         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  mode_q <= cmd_mode;
                  bot_q  <= cmd_kern_bot;
                  mid_q  <= cmd_kern_mid;
                  top_q  <= cmd_kern_top;
                  if (cmd_mode == 2'd3) begin
                     err_mode <= 1'b1;
                  end else begin
                     state     <= S_ARMED;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            S_ARMED: begin
               if (boundary) begin
                  state        <= S_WRITE;
                  idx          <= 2'd0;
                  addr_out     <= entry_addr(mode_q, 2'd0);
                  wr_data_out  <= entry_data(mode_q, 2'd0, bot_q, mid_q, top_q);
                  write_en_out <= 1'b1;
               end
            end
            S_WRITE: begin
               state   <= S_GAP;
               gap_cnt <= GAP_LOAD;
            end
            S_GAP: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
`ifdef CFG_READBACK_EN
               else state <= S_VERIFY;
`endif
            end
`ifdef CFG_READBACK_EN
            S_VERIFY: begin
               if (rd_data_in != wr_data_out) err_rb <= 1'b1;
            end
`endif
            default: state <= S_IDLE;
         endcase

         // Entry finished: either start the next write or retire the command.
         if (entry_end) begin
            if (last_entry) begin
               state    <= S_IDLE;
               cur_mode <= mode_q;
               cfg_done <= 1'b1;
               busy     <= 1'b0;
            end else begin
               state        <= S_WRITE;
               idx          <= nxt_idx;
               addr_out     <= nxt_addr;
               wr_data_out  <= nxt_data;
               write_en_out <= 1'b1;
            end
         end
      end
   end

endmodule
